disp_msg_arbiter: RTL
=====================

// Module: disp_msg_arbiter
// PURPOSE
//  Shares the 16-char alphanumeric display between two message sources and an idle/default frame.
//  Picks one source, holds its frame for a minimum display time and registers the 640-bit dots bus.
//  Sits in front of the display driver and drives its dots input.
//  Requesters are round-robin, so a continuously requesting source cannot starve the other.
// PARAMETERS
//  HOLD_CYCLES  27000000  minimum clock_27mhz cycles a granted frame stays shown (>=1; default 1 s)
// PORTS
//  clock_27mhz   in   1    system clock; all state on posedge
//  reset_b       in   1    asynchronous, active-low reset
//  req0          in   1    source 0 requests the display (level)
//  dots0         in   640  source 0 frame; bit 639 = first dot shifted out
//  req1          in   1    source 1 requests the display (level)
//  dots1         in   640  source 1 frame
//  dots_default  in   640  frame shown when no source owns the display
//  gnt0          out  1    source 0 currently owns the display and is requesting
//  gnt1          out  1    source 1 currently owns the display and is requesting
//  busy          out  1    a source owns the display (state SHOW0/SHOW1)
//  dots_out      out  640  registered frame to the display driver
// BEHAVIOUR
//  Reset (reset_b=0, async): state=IDLE, gnt0=gnt1=0, busy=0, dots_out=0, hold_cnt=0, rr_last=1 (source 0 wins first tie).
//  hold_cnt width is $clog2(HOLD_CYCLES+1). It loads HOLD_CYCLES-1 on every grant and decrements to 0, saturating.
//  expired = (hold_cnt==0).
//  States:
//   IDLE: dots_out<=dots_default each cycle.
//    Any req high -> grant source; if both high, grant the source != rr_last.
//    On the grant edge: state<=SHOWn, gntn<=1, busy<=1, dots_out<=dotsn, hold_cnt<=HOLD_CYCLES-1, rr_last<=n.
//   SHOWn while reqn=1: dots_out<=dotsn every cycle (live frame); gntn=1.
//   SHOWn while reqn=0: gntn<=0 on the next edge; dots_out frozen at the last captured frame.
//   Leaving SHOWn (evaluated only when expired):
//    other req=1 -> switch directly to SHOWm. Same edge: gntn<=0, gntm<=1, dots_out<=dotsm, reload hold_cnt, rr_last<=m. No IDLE cycle.
//    else reqn=1 -> stay, keep streaming.
//    else -> IDLE; dots_out<=dots_default on that edge; busy<=0.
//  Latency: req sampled high in IDLE -> gnt and dots_out updated 1 edge later.
//  A frame is shown >= HOLD_CYCLES cycles even if the requester drops req after 1 cycle.
//  HOLD_CYCLES=1: expired is true the cycle after every grant; arbitration is then purely round-robin per cycle.
//  gnt0 and gnt1 are never high together; busy = (state!=IDLE).
//  Reset mid-frame: immediate return to reset values; no partial state is retained.
// CONFIGURATION
//  DISP_ARB_PRIO_EN defined: source 0 has fixed priority.
//   req0 high in SHOW1 switches to SHOW0 on the next edge, ignoring hold_cnt.
//   Ties in IDLE always go to 0; rr_last is unused.
//   Source 1 cannot preempt SHOW0, even after expiry; it is granted only on exit per the rules above.
//  DISP_ARB_PRIO_EN undefined: round-robin and hold rules exactly as in BEHAVIOUR.
// TESTING (bench uses HOLD_CYCLES=8)
//  Idle: no reqs, dots_default=640'hA5.. -> dots_out equals dots_default 1 edge later; busy=0.
//  Short req: req0 pulsed 1 cycle with dots0=all-ones -> gnt0 high 1 cycle.
//   dots_out=all-ones for exactly 8 cycles, then dots_default; busy falls with it.
//  Tie: req0=req1=1 from reset -> SHOW0 first.
//   Both held: ownership alternates 0,1,0 every 8 cycles; gnt one-hot; no IDLE cycle.
//  Live update: req1 held, dots1 changes each cycle -> dots_out tracks dots1 with 1-cycle lag.
//  Reset mid-SHOW1 (reset_b low 1 cycle at hold_cnt=3) -> all outputs 0 immediately.
//   After release, the tie rule again grants source 0 first.
//  DISP_ARB_PRIO_EN: in SHOW1 at hold_cnt=6, raise req0 -> gnt1=0, gnt0=1, dots_out=dots0 on the next edge.

Source files
------------

// File: rtl/disp_msg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : disp_msg_arbiter
// Brief    : Shares the 16-char display between two message sources and a
//            default frame, with a minimum hold time per granted frame.
//            Define DISP_ARB_PRIO_EN to give source 0 fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module disp_msg_arbiter #(
   parameter int HOLD_CYCLES = 27000000
) (
   input  logic         clock_27mhz,
   input  logic         reset_b,
   input  logic         req0,
   input  logic [639:0] dots0,
   input  logic         req1,
   input  logic [639:0] dots1,
   input  logic [639:0] dots_default,
   output logic         gnt0,
   output logic         gnt1,
   output logic         busy,
   output logic [639:0] dots_out
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] c_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW0 = 2'd1,
      ST_SHOW1 = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_hold_cnt;
   logic             w_expired;
   logic             w_take0;
   logic             w_take1;
   logic             w_release;

   assign w_expired = (r_hold_cnt == '0);

`ifdef DISP_ARB_PRIO_EN
   always_comb begin
      w_take0   = 1'b0;
      w_take1   = 1'b0;
      w_release = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_take0 = req0;
            w_take1 = !req0 && req1;
         end
         ST_SHOW0: begin
            // source 0 keeps the display for as long as it asks for it
            if (w_expired && !req0) begin
               w_take1   = req1;
               w_release = !req1;
            end
         end
         ST_SHOW1: begin
            if (req0)
               w_take0 = 1'b1;
            else if (w_expired)
               w_release = !req1;
         end
         default: w_release = 1'b1;
      endcase
   end
`else
   logic r_rr_last;

   always_ff @(posedge clock_27mhz or negedge reset_b) begin
      if (!reset_b)
         r_rr_last <= 1'b1;
      else if (w_take0)
         r_rr_last <= 1'b0;
      else if (w_take1)
         r_rr_last <= 1'b1;
   end

   always_comb begin
      w_take0   = 1'b0;
      w_take1   = 1'b0;
      w_release = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_take0 = req0 && (!req1 || r_rr_last);
            w_take1 = req1 && !w_take0;
         end
         ST_SHOW0: begin
            if (w_expired) begin
               w_take1   = req1;
               w_release = !req1 && !req0;
            end
         end
         ST_SHOW1: begin
            if (w_expired) begin
               w_take0   = req0;
               w_release = !req0 && !req1;
            end
         end
         default: w_release = 1'b1;
      endcase
   end
`endif

   always_ff @(posedge clock_27mhz or negedge reset_b) begin
      if (!reset_b) begin
         r_state    <= ST_IDLE;
         r_hold_cnt <= '0;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         busy       <= 1'b0;
         dots_out   <= '0;
      end else if (w_take0) begin
         r_state    <= ST_SHOW0;
         r_hold_cnt <= c_HOLD_LOAD;
         gnt0       <= 1'b1;
         gnt1       <= 1'b0;
         busy       <= 1'b1;
         dots_out   <= dots0;
      end else if (w_take1) begin
         r_state    <= ST_SHOW1;
         r_hold_cnt <= c_HOLD_LOAD;
         gnt0       <= 1'b0;
         gnt1       <= 1'b1;
         busy       <= 1'b1;
         dots_out   <= dots1;
      end else if (w_release) begin
         r_state    <= ST_IDLE;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         busy       <= 1'b0;
         dots_out   <= dots_default;
      end else begin
         if (!w_expired)
            r_hold_cnt <= r_hold_cnt - 1'b1;
         case (r_state)
            ST_SHOW0: begin
               // a dropped request freezes the last captured frame
               gnt0 <= req0;
               if (req0)
                  dots_out <= dots0;
            end
            ST_SHOW1: begin
               gnt1 <= req1;
               if (req1)
                  dots_out <= dots1;
            end
            default: dots_out <= dots_default;
         endcase
      end
   end

endmodule
`default_nettype wire
